// File: rtl/mii_rx_deframer.sv
// ============================================================================
// Module      : mii_rx_deframer
// Description : 64-bit MII receive deframer. Strips start/preamble/SFD and
//               emits payload words with keep, last, error and byte length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mii_rx_deframer #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int MAX_LEN    = 1518
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CTRL_WIDTH-1:0] o_keep,
    output logic                  o_valid,
    output logic                  o_last,
    output logic                  o_err,
    output logic [15:0]           o_len
);

    localparam logic [7:0]  c_idle     = 8'h07;
    localparam logic [7:0]  c_start    = 8'hFB;
    localparam logic [7:0]  c_term     = 8'hFD;
    localparam logic [55:0] c_preamble = 56'hD5_5555_5555_5555;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t r_state, w_state_nx;

    logic [DATA_WIDTH-1:0] r_hold_data, w_hold_data_nx;
    logic [CTRL_WIDTH-1:0] r_hold_keep, w_hold_keep_nx;
    logic                  r_hold_valid, w_hold_valid_nx;
    logic                  r_hold_last, w_hold_last_nx;
    logic [15:0]           r_cnt, w_cnt_nx;

    logic [DATA_WIDTH-1:0] r_data, w_data_nx;
    logic [CTRL_WIDTH-1:0] r_keep, w_keep_nx;
    logic                  r_valid, w_valid_nx;
    logic                  r_last, w_last_nx;
    logic                  r_err, w_err_nx;
    logic [15:0]           r_len, w_len_nx;

    // Word classification
    logic                  w_is_start, w_start_ok;
    logic                  w_found, w_has_t, w_all_idle, w_tail_ok, w_term_ok;
    logic [2:0]            w_term_lane;
    logic [7:0]            w_term_char;
    logic [DATA_WIDTH-1:0] w_part_data;
    logic [CTRL_WIDTH-1:0] w_part_keep;
    logic [15:0]           w_sum8, w_sumt;

    always_comb begin
        w_is_start  = i_rx_ctrl[0] && (i_rx_data[7:0] == c_start);
        w_start_ok  = w_is_start && (i_rx_ctrl[CTRL_WIDTH-1:1] == '0) &&
                      (i_rx_data[DATA_WIDTH-1:8] == c_preamble);
        w_found     = 1'b0;
        w_has_t     = 1'b0;
        w_all_idle  = 1'b1;
        w_term_lane = 3'd0;
        w_term_char = 8'h00;
        for (int i = 0; i < CTRL_WIDTH; i++) begin
            if (!i_rx_ctrl[i] || (i_rx_data[8*i +: 8] != c_idle))
                w_all_idle = 1'b0;
            if (i_rx_ctrl[i] && (i_rx_data[8*i +: 8] == c_term))
                w_has_t = 1'b1;
            if (!w_found && i_rx_ctrl[i]) begin
                w_found     = 1'b1;
                w_term_lane = 3'(i);
                w_term_char = i_rx_data[8*i +: 8];
            end
        end
        // Lanes past T must be idles; lanes before T are payload
        w_tail_ok   = 1'b1;
        w_part_data = '0;
        for (int i = 0; i < CTRL_WIDTH; i++) begin
            if ((3'(i) > w_term_lane) && !(i_rx_ctrl[i] && (i_rx_data[8*i +: 8] == c_idle)))
                w_tail_ok = 1'b0;
            if (3'(i) < w_term_lane)
                w_part_data[8*i +: 8] = i_rx_data[8*i +: 8];
        end
        w_term_ok   = w_found && (w_term_char == c_term) && w_tail_ok;
        w_part_keep = 8'((9'd1 << w_term_lane) - 9'd1);
        w_sum8      = r_cnt + 16'd8;
        w_sumt      = r_cnt + 16'(w_term_lane);
    end

    always_comb begin
        w_state_nx      = r_state;
        w_hold_data_nx  = r_hold_data;
        w_hold_keep_nx  = r_hold_keep;
        w_hold_valid_nx = r_hold_valid;
        w_hold_last_nx  = r_hold_last;
        w_cnt_nx        = r_cnt;
        w_data_nx       = '0;
        w_keep_nx       = '0;
        w_valid_nx      = 1'b0;
        w_last_nx       = 1'b0;
        w_err_nx        = 1'b0;
        w_len_nx        = 16'd0;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_last) begin
                    w_valid_nx      = 1'b1;
                    w_data_nx       = r_hold_data;
                    w_keep_nx       = r_hold_keep;
                    w_last_nx       = 1'b1;
                    w_len_nx        = r_cnt;
                    w_hold_valid_nx = 1'b0;
                    w_hold_last_nx  = 1'b0;
                end
                if (w_start_ok) begin
                    w_state_nx = ST_DATA;
                    w_cnt_nx   = 16'd0;
                end else if (w_is_start) begin
                    w_state_nx = ST_DROP;
                end
            end
            ST_DATA: begin
                if ((i_rx_ctrl == '0) && (w_sum8 <= 16'(MAX_LEN))) begin
                    if (r_hold_valid) begin
                        w_valid_nx = 1'b1;
                        w_data_nx  = r_hold_data;
                        w_keep_nx  = '1;
                    end
                    w_hold_data_nx  = i_rx_data;
                    w_hold_keep_nx  = '1;
                    w_hold_valid_nx = 1'b1;
                    w_cnt_nx        = w_sum8;
                end else if (w_term_ok && (w_sumt <= 16'(MAX_LEN))) begin
                    w_state_nx = ST_IDLE;
                    if (r_hold_valid) begin
                        w_valid_nx = 1'b1;
                        w_data_nx  = r_hold_data;
                        w_keep_nx  = r_hold_keep;
                        w_last_nx  = (w_term_lane == 3'd0);
                        w_len_nx   = (w_term_lane == 3'd0) ? r_cnt : 16'd0;
                    end
                    w_hold_valid_nx = (w_term_lane != 3'd0);
                    w_hold_last_nx  = (w_term_lane != 3'd0);
                    w_hold_data_nx  = w_part_data;
                    w_hold_keep_nx  = w_part_keep;
                    w_cnt_nx        = w_sumt;
                end else begin
                    // Errors close the frame with whatever was held, possibly nothing
                    w_state_nx      = ST_DROP;
                    w_valid_nx      = 1'b1;
                    w_data_nx       = r_hold_valid ? r_hold_data : '0;
                    w_keep_nx       = r_hold_valid ? r_hold_keep : '0;
                    w_last_nx       = 1'b1;
                    w_err_nx        = 1'b1;
                    w_len_nx        = r_cnt;
                    w_hold_valid_nx = 1'b0;
                    w_hold_last_nx  = 1'b0;
                end
            end
            ST_DROP: begin
                if (w_has_t || w_all_idle)
                    w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_hold_data  <= '0;
            r_hold_keep  <= '0;
            r_hold_valid <= 1'b0;
            r_hold_last  <= 1'b0;
            r_cnt        <= 16'd0;
            r_data       <= '0;
            r_keep       <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_err        <= 1'b0;
            r_len        <= 16'd0;
        end else begin
            r_state      <= w_state_nx;
            r_hold_data  <= w_hold_data_nx;
            r_hold_keep  <= w_hold_keep_nx;
            r_hold_valid <= w_hold_valid_nx;
            r_hold_last  <= w_hold_last_nx;
            r_cnt        <= w_cnt_nx;
            r_data       <= w_data_nx;
            r_keep       <= w_keep_nx;
            r_valid      <= w_valid_nx;
            r_last       <= w_last_nx;
            r_err        <= w_err_nx;
            r_len        <= w_len_nx;
        end
    end

    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_err   = r_err;
    assign o_len   = r_len;

endmodule

`default_nettype wire

// File: tb/tb_mii_rx_deframer.sv
// ============================================================================
// Module      : tb_mii_rx_deframer
// Description : Directed self-checking bench for mii_rx_deframer (MAX_LEN=64).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mii_rx_deframer;

    localparam logic [63:0] c_idlew  = 64'h0707070707070707;
    localparam logic [63:0] c_startw = 64'hD5555555555555FB;
    localparam logic [63:0] c_badst  = 64'hD4555555555555FB;
    localparam logic [63:0] c_term0  = 64'h07070707070707FD;
    localparam logic [63:0] c_term3  = 64'h07070707FDCCBBAA;
    localparam logic [63:0] c_errw   = 64'h3333333333FE3333;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [63:0] i_rx_data = c_idlew;
    logic [7:0]  i_rx_ctrl = 8'hFF;
    logic [63:0] o_data;
    logic [7:0]  o_keep;
    logic        o_valid, o_last, o_err;
    logic [15:0] o_len;

    int total = 0;
    int bad   = 0;

    mii_rx_deframer #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .MAX_LEN(64)) dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_rx_data (i_rx_data),
        .i_rx_ctrl (i_rx_ctrl),
        .o_data    (o_data),
        .o_keep    (o_keep),
        .o_valid   (o_valid),
        .o_last    (o_last),
        .o_err     (o_err),
        .o_len     (o_len)
    );

    always #5 clk = ~clk;

    function automatic logic [90:0] pk(logic v, logic l, logic e, logic [7:0] k,
                                       logic [15:0] len, logic [63:0] d);
        return {v, l, e, k, len, d};
    endfunction

    task automatic chk(input string tag, input logic [90:0] exp);
        logic [90:0] obs;
        obs = {o_valid, o_last, o_err, o_keep, o_len, o_data};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] c);
        i_rx_data = d;
        i_rx_ctrl = c;
        @(posedge clk);
        #1;
    endtask

    task automatic sendd(input logic [63:0] d);
        send(d, 8'h00);
    endtask

    logic [90:0] c_none;
    logic [63:0] w;

    initial begin
        c_none = '0;
        // Reset state
        send(c_idlew, 8'hFF);
        chk("reset", c_none);
        #2 i_rst = 1'b1;
        send(c_idlew, 8'hFF);
        chk("idle", c_none);

        // Two full words, terminate in lane 0
        send(c_startw, 8'h01);                 chk("t1_start", c_none);
        sendd({8{8'h11}});                     chk("t1_w1_hold", c_none);
        sendd({8{8'h22}});                     chk("t1_w1", pk(1, 0, 0, 8'hFF, 0, {8{8'h11}}));
        send(c_term0, 8'hFF);                  chk("t1_w2_last", pk(1, 1, 0, 8'hFF, 16, {8{8'h22}}));
        send(c_idlew, 8'hFF);                  chk("t1_after", c_none);

        // Terminate in lane 3
        send(c_startw, 8'h01);                 chk("t2_start", c_none);
        sendd({8{8'h44}});                     chk("t2_hold", c_none);
        send(c_term3, 8'hF8);                  chk("t2_full", pk(1, 0, 0, 8'hFF, 0, {8{8'h44}}));
        send(c_idlew, 8'hFF);                  chk("t2_part", pk(1, 1, 0, 8'h07, 11, 64'h0000000000CCBBAA));
        send(c_idlew, 8'hFF);                  chk("t2_after", c_none);

        // Bad SFD: whole frame dropped, then clean frame
        send(c_badst, 8'h01);                  chk("t3_bad", c_none);
        sendd({8{8'h12}});                     chk("t3_d1", c_none);
        sendd({8{8'h13}});                     chk("t3_d2", c_none);
        sendd({8{8'h14}});                     chk("t3_d3", c_none);
        send(c_term0, 8'hFF);                  chk("t3_term", c_none);
        send(c_startw, 8'h01);                 chk("t3_start", c_none);
        sendd({8{8'h66}});                     chk("t3_hold", c_none);
        send(c_term0, 8'hFF);                  chk("t3_good", pk(1, 1, 0, 8'hFF, 8, {8{8'h66}}));

        // Error character in third payload word
        send(c_startw, 8'h01);                 chk("t4_start", c_none);
        sendd({8{8'h77}});                     chk("t4_hold", c_none);
        sendd({8{8'h88}});                     chk("t4_w1", pk(1, 0, 0, 8'hFF, 0, {8{8'h77}}));
        send(c_errw, 8'h04);                   chk("t4_err", pk(1, 1, 1, 8'hFF, 16, {8{8'h88}}));
        sendd({8{8'h99}});                     chk("t4_drop", c_none);
        send(c_term0, 8'hFF);                  chk("t4_term", c_none);
        send(c_startw, 8'h01);                 chk("t4_start2", c_none);
        sendd({8{8'h9A}});                     chk("t4_hold2", c_none);
        send(c_term0, 8'hFF);                  chk("t4_clean", pk(1, 1, 0, 8'hFF, 8, {8{8'h9A}}));

        // Zero-payload frame, then error on first word after start
        send(c_startw, 8'h01);                 chk("t5_start", c_none);
        send(c_term0, 8'hFF);                  chk("t5_zero", c_none);
        send(c_startw, 8'h01);                 chk("t5_start2", c_none);
        send(c_errw, 8'h04);                   chk("t5_err_empty", pk(1, 1, 1, 8'h00, 0, 64'h0));
        send(c_idlew, 8'hFF);                  chk("t5_after", c_none);

        // Exactly MAX_LEN bytes passes
        send(c_startw, 8'h01);
        for (int i = 1; i <= 8; i++) begin
            w = {8{8'(i)}};
            sendd(w);
        end
        send(c_term0, 8'hFF);                  chk("t6_len64", pk(1, 1, 0, 8'hFF, 64, {8{8'h08}}));

        // Oversize: ninth word overflows
        send(c_startw, 8'h01);
        for (int i = 1; i <= 8; i++) begin
            w = {8{8'(8'h20 + i)}};
            sendd(w);
        end
        chk("t7_w7", pk(1, 0, 0, 8'hFF, 0, {8{8'h27}}));
        sendd({8{8'h29}});                     chk("t7_over", pk(1, 1, 1, 8'hFF, 64, {8{8'h28}}));
        sendd({8{8'h2A}});                     chk("t7_drop", c_none);
        send(c_term0, 8'hFF);                  chk("t7_term", c_none);

        // Flush of last-pending word alongside back-to-back start
        send(c_startw, 8'h01);
        sendd({8{8'hAB}});
        send(c_term3, 8'hF8);                  chk("t8_full", pk(1, 0, 0, 8'hFF, 0, {8{8'hAB}}));
        send(c_startw, 8'h01);                 chk("t8_flush", pk(1, 1, 0, 8'h07, 11, 64'h0000000000CCBBAA));
        sendd({8{8'hBC}});                     chk("t8_hold", c_none);
        send(c_term0, 8'hFF);                  chk("t8_second", pk(1, 1, 0, 8'hFF, 8, {8{8'hBC}}));

        // Asynchronous reset mid-frame
        send(c_startw, 8'h01);
        sendd({8{8'hC1}});
        sendd({8{8'hC2}});                     chk("t9_w1", pk(1, 0, 0, 8'hFF, 0, {8{8'hC1}}));
        #1 i_rst = 1'b0;
        #1 chk("t9_async", c_none);
        @(posedge clk);
        #1 i_rst = 1'b1;
        sendd({8{8'hC3}});                     chk("t9_ign1", c_none);
        send(c_term0, 8'hFF);                  chk("t9_ign2", c_none);
        send(c_startw, 8'h01);
        sendd({8{8'hC4}});
        send(c_term0, 8'hFF);                  chk("t9_recover", pk(1, 1, 0, 8'hFF, 8, {8{8'hC4}}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
